// File: rtl/hazard_scoreboard_if.sv
// Decode-side handshake between the ID stage and the hazard scoreboard.
// The decoder (master) presents the instruction being decoded plus the flush
// request; the scoreboard (slave) answers with the stall and the EX operand
// forward selects.
interface hazard_scoreboard_if #(
    parameter int REG_W = 6
);
    logic             id_valid;
    logic [REG_W-1:0] id_rs;
    logic [REG_W-1:0] id_rt;
    logic             id_rs_used;
    logic             id_rt_used;
    logic [REG_W-1:0] id_rd;
    logic             id_wr;
    logic             id_load;
    logic             flush;
    logic             stall;
    logic [1:0]       fwd_a;
    logic [1:0]       fwd_b;

    modport master (
        output id_valid, id_rs, id_rt, id_rs_used, id_rt_used,
               id_rd, id_wr, id_load, flush,
        input  stall, fwd_a, fwd_b
    );

    modport slave (
        input  id_valid, id_rs, id_rt, id_rs_used, id_rt_used,
               id_rd, id_wr, id_load, flush,
        output stall, fwd_a, fwd_b
    );
endinterface

// File: rtl/hazard_scoreboard.sv
// Hazard scoreboard sitting beside the ID/EX pipeline register.
// Shadows the destination of every instruction in EX, MEM and WB, raises a
// combinational load-use stall toward ID, and registers the EX operand
// forward selects so they arrive together with the operands in EX.
module hazard_scoreboard #(
    parameter int REG_W = 6,
    parameter int CNT_W = 16
) (
    input  logic                 clock,
    input  logic                 rst_n,
    hazard_scoreboard_if.slave   sb,
    output logic [CNT_W-1:0]     stall_count
);

    // Only the EX-resident copy needs the load flag: a load can only cause a
    // stall while it sits in EX, later slots always forward.
    typedef struct packed {
        logic             valid;
        logic [REG_W-1:0] rd;
        logic             wr;
    } slot_t;

    localparam logic [1:0] FWD_RF  = 2'b00;
    localparam logic [1:0] FWD_EX  = 2'b01;
    localparam logic [1:0] FWD_MEM = 2'b10;
    localparam logic [1:0] FWD_WB  = 2'b11;

    slot_t            exSlot_q, memSlot_q, wbSlot_q;
    slot_t            exSlot_d;
    logic             exLoad_q, exLoad_d;
    logic [1:0]       fwdA_q, fwdA_d;
    logic [1:0]       fwdB_q, fwdB_d;
    logic [CNT_W-1:0] stallCount_q, stallCount_d;
    logic             stallNow;
    logic             bubble;

    // A slot supplies a source when it writes that non-zero register and the
    // instruction actually reads the source; r0 is hard-wired and never matches.
    function automatic logic slotMatch(input slot_t s,
                                       input logic [REG_W-1:0] src,
                                       input logic used);
        return s.valid & s.wr & (s.rd == src) & (s.rd != '0) & used;
    endfunction

    // Nearest producer wins, so EX is checked before MEM before WB.
    function automatic logic [1:0] fwdSel(input slot_t ex, input slot_t mem,
                                          input slot_t wb,
                                          input logic [REG_W-1:0] src,
                                          input logic used);
        if (slotMatch(ex, src, used))       return FWD_EX;
        else if (slotMatch(mem, src, used)) return FWD_MEM;
        else if (slotMatch(wb, src, used))  return FWD_WB;
        else                                return FWD_RF;
    endfunction

    // Stall detection, EX admission and next forward selects for the
    // instruction about to move from ID into EX.
    always_comb begin
        stallNow     = 1'b0;
        bubble       = 1'b1;
        exSlot_d     = '0;
        exLoad_d     = 1'b0;
        fwdA_d       = FWD_RF;
        fwdB_d       = FWD_RF;
        stallCount_d = stallCount_q;

        stallNow = sb.id_valid & ~sb.flush & exLoad_q &
                   (slotMatch(exSlot_q, sb.id_rs, sb.id_rs_used) |
                    slotMatch(exSlot_q, sb.id_rt, sb.id_rt_used));
        bubble   = stallNow | sb.flush | ~sb.id_valid;

        if (!bubble) begin
            exSlot_d = '{valid: 1'b1, rd: sb.id_rd, wr: sb.id_wr};
            exLoad_d = sb.id_load;
            fwdA_d   = fwdSel(exSlot_q, memSlot_q, wbSlot_q, sb.id_rs, sb.id_rs_used);
            fwdB_d   = fwdSel(exSlot_q, memSlot_q, wbSlot_q, sb.id_rt, sb.id_rt_used);
        end

        if (stallNow && (stallCount_q != '1)) begin
            stallCount_d = stallCount_q + CNT_W'(1);
        end
    end

    // Slot shift register, forward-select registers and the saturating
    // stall counter; reset discards all in-flight state at once.
    always_ff @(posedge clock or negedge rst_n) begin
        if (!rst_n) begin
            exSlot_q     <= '0;
            memSlot_q    <= '0;
            wbSlot_q     <= '0;
            exLoad_q     <= 1'b0;
            fwdA_q       <= FWD_RF;
            fwdB_q       <= FWD_RF;
            stallCount_q <= '0;
        end else begin
            wbSlot_q     <= memSlot_q;
            memSlot_q    <= exSlot_q;
            exSlot_q     <= exSlot_d;
            exLoad_q     <= exLoad_d;
            fwdA_q       <= fwdA_d;
            fwdB_q       <= fwdB_d;
            stallCount_q <= stallCount_d;
        end
    end

    assign sb.stall    = stallNow;
    assign sb.fwd_a    = fwdA_q;
    assign sb.fwd_b    = fwdB_q;
    assign stall_count = stallCount_q;

endmodule

// File: tb/tb_hazard_scoreboard.sv
// Directed testbench for hazard_scoreboard: each scenario task drives a
// short instruction sequence and compares stall, forward selects and the
// stall counter against hand-derived values.
module tb_hazard_scoreboard;

    localparam int REG_W = 6;
    localparam int CNT_W = 8;

    logic             clock = 1'b0;
    logic             rst_n;
    logic [CNT_W-1:0] stallCount;
    int               checks = 0;
    int               errors = 0;

    hazard_scoreboard_if #(.REG_W(REG_W)) sbIf ();

    hazard_scoreboard #(.REG_W(REG_W), .CNT_W(CNT_W)) dut (
        .clock       (clock),
        .rst_n       (rst_n),
        .sb          (sbIf),
        .stall_count (stallCount)
    );

    // Free-running 10-time-unit clock.
    always #5 clock = ~clock;

    task automatic tick;
        @(posedge clock);
        #1;
    endtask

    task automatic drive(input logic v,
                         input logic [REG_W-1:0] rs, input logic rsU,
                         input logic [REG_W-1:0] rt, input logic rtU,
                         input logic [REG_W-1:0] rd, input logic wr,
                         input logic ld, input logic fl);
        sbIf.id_valid   = v;
        sbIf.id_rs      = rs;
        sbIf.id_rs_used = rsU;
        sbIf.id_rt      = rt;
        sbIf.id_rt_used = rtU;
        sbIf.id_rd      = rd;
        sbIf.id_wr      = wr;
        sbIf.id_load    = ld;
        sbIf.flush      = fl;
    endtask

    task automatic idle(input int n);
        drive(1'b0, 6'd0, 1'b0, 6'd0, 1'b0, 6'd0, 1'b0, 1'b0, 1'b0);
        repeat (n) tick;
    endtask

    task automatic test_reset;
        rst_n = 1'b0;
        drive(1'b0, 6'd0, 1'b0, 6'd0, 1'b0, 6'd0, 1'b0, 1'b0, 1'b0);
        #3;
        checks++;
        if (stallCount !== 8'd0) begin
            errors++;
            $display("[TB] FAIL por_count: got %0d expected 0", stallCount);
        end
        checks++;
        if (sbIf.fwd_a !== 2'b00 || sbIf.fwd_b !== 2'b00) begin
            errors++;
            $display("[TB] FAIL por_fwd: got %b/%b expected 00/00", sbIf.fwd_a, sbIf.fwd_b);
        end
        @(negedge clock);
        rst_n = 1'b1;
        // load r7, then a load r12 that reads r7 (stalls once), then reader of r12
        drive(1'b1, 6'd0, 1'b0, 6'd0, 1'b0, 6'd7, 1'b1, 1'b1, 1'b0);
        tick;
        drive(1'b1, 6'd7, 1'b1, 6'd0, 1'b0, 6'd12, 1'b1, 1'b1, 1'b0);
        #1;
        checks++;
        if (sbIf.stall !== 1'b1) begin
            errors++;
            $display("[TB] FAIL pre_reset_stall1: got %b expected 1", sbIf.stall);
        end
        tick;
        tick;
        drive(1'b1, 6'd0, 1'b0, 6'd12, 1'b1, 6'd13, 1'b1, 1'b0, 1'b0);
        #1;
        checks++;
        if (sbIf.fwd_a !== 2'b10 || stallCount !== 8'd1 || sbIf.stall !== 1'b1) begin
            errors++;
            $display("[TB] FAIL pre_reset_state: got fwd_a=%b cnt=%0d stall=%b expected 10/1/1",
                     sbIf.fwd_a, stallCount, sbIf.stall);
        end
        rst_n = 1'b0;
        #1;
        checks++;
        if (sbIf.stall !== 1'b0) begin
            errors++;
            $display("[TB] FAIL reset_stall: got %b expected 0", sbIf.stall);
        end
        checks++;
        if (sbIf.fwd_a !== 2'b00 || sbIf.fwd_b !== 2'b00) begin
            errors++;
            $display("[TB] FAIL reset_fwd: got %b/%b expected 00/00", sbIf.fwd_a, sbIf.fwd_b);
        end
        checks++;
        if (stallCount !== 8'd0) begin
            errors++;
            $display("[TB] FAIL reset_count: got %0d expected 0", stallCount);
        end
        #1;
        rst_n = 1'b1;
        tick;
        checks++;
        if (sbIf.fwd_b !== 2'b00 || sbIf.stall !== 1'b0) begin
            errors++;
            $display("[TB] FAIL post_reset_hazard: got fwd_b=%b stall=%b expected 00/0",
                     sbIf.fwd_b, sbIf.stall);
        end
    endtask

    task automatic test_alu_forward;
        idle(3);
        drive(1'b1, 6'd1, 1'b1, 6'd2, 1'b1, 6'd3, 1'b1, 1'b0, 1'b0);
        tick;
        drive(1'b1, 6'd3, 1'b1, 6'd8, 1'b1, 6'd4, 1'b1, 1'b0, 1'b0);
        #1;
        checks++;
        if (sbIf.stall !== 1'b0) begin
            errors++;
            $display("[TB] FAIL alu_stall: got %b expected 0", sbIf.stall);
        end
        tick;
        checks++;
        if (sbIf.fwd_a !== 2'b01 || sbIf.fwd_b !== 2'b00) begin
            errors++;
            $display("[TB] FAIL alu_fwd: got %b/%b expected 01/00", sbIf.fwd_a, sbIf.fwd_b);
        end
    endtask

    task automatic test_distance;
        logic [1:0] expSel;
        for (int d = 1; d <= 3; d++) begin
            idle(3);
            drive(1'b1, 6'd0, 1'b0, 6'd0, 1'b0, 6'd5, 1'b1, 1'b0, 1'b0);
            tick;
            for (int k = 0; k < d; k++) begin
                drive(1'b1, 6'd11, 1'b1, 6'd0, 1'b0, 6'd10, 1'b1, 1'b0, 1'b0);
                tick;
            end
            drive(1'b1, 6'd1, 1'b1, 6'd5, 1'b1, 6'd20, 1'b1, 1'b0, 1'b0);
            tick;
            case (d)
                1:       expSel = 2'b10;
                2:       expSel = 2'b11;
                default: expSel = 2'b00;
            endcase
            checks++;
            if (sbIf.fwd_b !== expSel || sbIf.fwd_a !== 2'b00) begin
                errors++;
                $display("[TB] FAIL distance_%0d: got %b/%b expected 00/%b",
                         d, sbIf.fwd_a, sbIf.fwd_b, expSel);
            end
        end
    endtask

    task automatic test_load_use;
        idle(3);
        drive(1'b1, 6'd0, 1'b0, 6'd0, 1'b0, 6'd7, 1'b1, 1'b1, 1'b0);
        tick;
        drive(1'b1, 6'd7, 1'b1, 6'd0, 1'b0, 6'd12, 1'b1, 1'b0, 1'b0);
        #1;
        checks++;
        if (sbIf.stall !== 1'b1) begin
            errors++;
            $display("[TB] FAIL loaduse_stall: got %b expected 1", sbIf.stall);
        end
        tick;
        checks++;
        if (sbIf.fwd_a !== 2'b00 || sbIf.stall !== 1'b0) begin
            errors++;
            $display("[TB] FAIL loaduse_bubble: got fwd_a=%b stall=%b expected 00/0",
                     sbIf.fwd_a, sbIf.stall);
        end
        tick;
        checks++;
        if (sbIf.fwd_a !== 2'b10) begin
            errors++;
            $display("[TB] FAIL loaduse_fwd: got %b expected 10", sbIf.fwd_a);
        end
        checks++;
        if (stallCount !== 8'd1) begin
            errors++;
            $display("[TB] FAIL loaduse_count: got %0d expected 1", stallCount);
        end
    endtask

    task automatic test_reg0_priority;
        idle(3);
        drive(1'b1, 6'd0, 1'b0, 6'd0, 1'b0, 6'd0, 1'b1, 1'b1, 1'b0);
        tick;
        drive(1'b1, 6'd0, 1'b1, 6'd0, 1'b0, 6'd9, 1'b1, 1'b0, 1'b0);
        #1;
        checks++;
        if (sbIf.stall !== 1'b0) begin
            errors++;
            $display("[TB] FAIL reg0_stall: got %b expected 0", sbIf.stall);
        end
        tick;
        checks++;
        if (sbIf.fwd_a !== 2'b00) begin
            errors++;
            $display("[TB] FAIL reg0_fwd: got %b expected 00", sbIf.fwd_a);
        end
        idle(3);
        drive(1'b1, 6'd0, 1'b0, 6'd0, 1'b0, 6'd4, 1'b1, 1'b0, 1'b0);
        tick;
        tick;
        drive(1'b1, 6'd4, 1'b1, 6'd4, 1'b1, 6'd6, 1'b1, 1'b0, 1'b0);
        tick;
        checks++;
        if (sbIf.fwd_a !== 2'b01 || sbIf.fwd_b !== 2'b01) begin
            errors++;
            $display("[TB] FAIL priority_fwd: got %b/%b expected 01/01", sbIf.fwd_a, sbIf.fwd_b);
        end
    endtask

    task automatic test_flush;
        idle(3);
        drive(1'b1, 6'd0, 1'b0, 6'd0, 1'b0, 6'd2, 1'b1, 1'b1, 1'b0);
        tick;
        drive(1'b1, 6'd2, 1'b1, 6'd0, 1'b0, 6'd14, 1'b1, 1'b0, 1'b1);
        #1;
        checks++;
        if (sbIf.stall !== 1'b0) begin
            errors++;
            $display("[TB] FAIL flush_stall: got %b expected 0", sbIf.stall);
        end
        tick;
        checks++;
        if (sbIf.fwd_a !== 2'b00 || stallCount !== 8'd1) begin
            errors++;
            $display("[TB] FAIL flush_bubble: got fwd_a=%b cnt=%0d expected 00/1",
                     sbIf.fwd_a, stallCount);
        end
        drive(1'b1, 6'd2, 1'b1, 6'd0, 1'b0, 6'd14, 1'b1, 1'b0, 1'b0);
        tick;
        checks++;
        if (sbIf.fwd_a !== 2'b10) begin
            errors++;
            $display("[TB] FAIL flush_refetch_fwd: got %b expected 10", sbIf.fwd_a);
        end
    endtask

    task automatic test_saturation;
        idle(3);
        // load r7 that also reads r7: stalls on every other cycle while held
        drive(1'b1, 6'd7, 1'b1, 6'd0, 1'b0, 6'd7, 1'b1, 1'b1, 1'b0);
        repeat (600) tick;
        checks++;
        if (stallCount !== 8'hFF) begin
            errors++;
            $display("[TB] FAIL sat_count: got %0d expected 255", stallCount);
        end
        idle(2);
        checks++;
        if (stallCount !== 8'hFF) begin
            errors++;
            $display("[TB] FAIL sat_hold: got %0d expected 255", stallCount);
        end
    endtask

    // Scenario sequencer.
    initial begin
        test_reset;
        test_alu_forward;
        test_distance;
        test_load_use;
        test_reg0_priority;
        test_flush;
        test_saturation;
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
